// File: rtl/dmem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_arbiter_if
// Purpose  : Request side and data-memory side signals of the dmem bus arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] ReqWriteBus;
    logic [32*NREQ-1:0] ReqAddrBus;
    logic [2*NREQ-1:0]  ReqWDM;
    logic [2*NREQ-1:0]  ReqRDM;
    logic [NREQ-1:0]    grt;
    logic [31:0]        MemWriteBus;
    logic [31:0]        MemAddrBus;
    logic [1:0]         WDMB;
    logic [1:0]         RDMB;
    logic               Busy;
    logic [1:0]         Owner;
    logic               Timeout;
    logic [1:0]         TimeoutOwner;

    modport master (
        output req, ReqWriteBus, ReqAddrBus, ReqWDM, ReqRDM,
        input  grt, MemWriteBus, MemAddrBus, WDMB, RDMB,
        input  Busy, Owner, Timeout, TimeoutOwner
    );

    modport slave (
        input  req, ReqWriteBus, ReqAddrBus, ReqWDM, ReqRDM,
        output grt, MemWriteBus, MemAddrBus, WDMB, RDMB,
        output Busy, Owner, Timeout, TimeoutOwner
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_arbiter
// Purpose  : Round-robin arbiter sharing the data-memory port among NREQ
//            masters, with a turnaround gap and a hold watchdog.
// Revision : 1.0
// ============================================================================
module dmem_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 255
) (
    input  wire logic         Clk,
    input  wire logic         Rst,
    dmem_bus_arbiter_if.slave bus
);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_GRANT    = 2'd1;
    localparam logic [1:0] c_GAP      = 2'd2;
    localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);
    localparam logic [1:0] c_LAST     = 2'(NREQ - 1);

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_grt;
    logic [NREQ-1:0] r_mask;
    logic [1:0]      r_owner;
    logic [7:0]      r_hold;
    logic            r_timeout;
    logic [1:0]      r_towner;

    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_own_oh;
    logic [NREQ-1:0] w_win_oh;
    logic [NREQ-1:0] w_mask_set;
    logic [1:0]      w_win;
    logic            w_found;
    logic            w_own_req;
    logic            w_force;
    logic            w_busy;

    logic [31:0] w_wdata [NREQ];
    logic [31:0] w_addr  [NREQ];
    logic [1:0]  w_wdm   [NREQ];
    logic [1:0]  w_rdm   [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign w_wdata[gi] = bus.ReqWriteBus[32*gi +: 32];
        assign w_addr[gi]  = bus.ReqAddrBus[32*gi +: 32];
        assign w_wdm[gi]   = bus.ReqWDM[2*gi +: 2];
        assign w_rdm[gi]   = bus.ReqRDM[2*gi +: 2];
    end

    assign w_cand  = bus.req & ~r_mask;
    assign w_found = |w_cand;
    assign w_busy  = (r_state == c_GRANT);

    // Walk from the farthest index back to Owner+1 so the nearest candidate
    // is the last one written.
    always_comb begin : p_search
        logic [1:0] v_idx;
        w_win = r_owner;
        v_idx = 2'd0;
        for (int k = NREQ; k >= 1; k--) begin
            v_idx = 2'((int'(r_owner) + k) % NREQ);
            if (w_cand[v_idx]) begin
                w_win = v_idx;
            end
        end
    end

    always_comb begin : p_onehot
        w_own_oh = '0;
        w_win_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_own_oh[i] = (r_owner == 2'(i));
            w_win_oh[i] = (w_win == 2'(i));
        end
    end

    assign w_own_req  = |(bus.req & w_own_oh);
    assign w_force    = w_busy && w_own_req && (r_hold == c_MAX_HOLD)
                        && (|(bus.req & ~w_own_oh));
    assign w_mask_set = w_force ? w_own_oh : '0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= c_IDLE;
            r_grt     <= '0;
            r_mask    <= '0;
            r_owner   <= c_LAST;
            r_hold    <= 8'd0;
            r_timeout <= 1'b0;
            r_towner  <= 2'd0;
        end else begin
            r_mask <= (r_mask | w_mask_set) & bus.req;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_grt   <= w_win_oh;
                        r_hold  <= 8'd1;
                        r_state <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    if (!w_own_req) begin
                        r_grt   <= '0;
                        r_state <= c_GAP;
                    end else if (w_force) begin
                        r_grt     <= '0;
                        r_timeout <= 1'b1;
                        if (!r_timeout) begin
                            r_towner <= r_owner;
                        end
                        r_state <= c_GAP;
                    end else if (r_hold != c_MAX_HOLD) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                c_GAP:   r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Outside GRANT every memory control drives zero so no access happens.
    always_comb begin : p_mux
        bus.MemWriteBus = 32'd0;
        bus.MemAddrBus  = 32'd0;
        bus.WDMB        = 2'd0;
        bus.RDMB        = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_busy && (r_owner == 2'(i))) begin
                bus.MemWriteBus = w_wdata[i];
                bus.MemAddrBus  = w_addr[i];
                bus.WDMB        = w_wdm[i];
                bus.RDMB        = w_rdm[i];
            end
        end
    end

    assign bus.grt          = r_grt;
    assign bus.Busy         = w_busy;
    assign bus.Owner        = r_owner;
    assign bus.Timeout      = r_timeout;
    assign bus.TimeoutOwner = r_towner;
endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bus_arbiter
// Purpose  : Directed scoreboard bench for dmem_bus_arbiter (NREQ=4, MAX_HOLD=4).
// Revision : 1.0
// ============================================================================
module tb_dmem_bus_arbiter;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    dmem_bus_arbiter_if #(.NREQ(4)) bus ();

    dmem_bus_arbiter #(.NREQ(4), .MAX_HOLD(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct packed {
        int          cyc;
        logic [3:0]  grt;
        logic        busy;
        logic [1:0]  owner;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [1:0]  wdm;
        logic [1:0]  rdm;
        logic        to;
        logic [1:0]  tow;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        e_to  = 1'b0;
    logic [1:0]  e_tow = 2'd0;

    logic [31:0] wdata_tab [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};
    logic [31:0] addr_tab  [4] = '{32'h0000_8000, 32'h0000_8100, 32'h0000_8200, 32'h0000_8300};
    logic [1:0]  wdm_tab   [4] = '{2'd1, 2'd0, 2'd3, 2'd0};
    logic [1:0]  rdm_tab   [4] = '{2'd0, 2'd3, 2'd0, 2'd1};

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic step(input logic rst_v, input logic [3:0] r);
        Rst     = rst_v;
        bus.req = r;
        @(posedge Clk);
        #1;
    endtask

    task automatic exp_g(input string nm, input int m);
        exp_t e;
        e.cyc   = cyc;
        e.grt   = 4'b0001 << m;
        e.busy  = 1'b1;
        e.owner = 2'(m);
        e.wdata = wdata_tab[m];
        e.addr  = addr_tab[m];
        e.wdm   = wdm_tab[m];
        e.rdm   = rdm_tab[m];
        e.to    = e_to;
        e.tow   = e_tow;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic exp_n(input string nm, input int o);
        exp_t e;
        e.cyc   = cyc;
        e.grt   = 4'b0000;
        e.busy  = 1'b0;
        e.owner = 2'(o);
        e.wdata = 32'd0;
        e.addr  = 32'd0;
        e.wdm   = 2'd0;
        e.rdm   = 2'd0;
        e.to    = e_to;
        e.tow   = e_tow;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: pops every expectation due in the current cycle.
    always @(negedge Clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.cyc   = e.cyc;
            a.grt   = bus.grt;
            a.busy  = bus.Busy;
            a.owner = bus.Owner;
            a.wdata = bus.MemWriteBus;
            a.addr  = bus.MemAddrBus;
            a.wdm   = bus.WDMB;
            a.rdm   = bus.RDMB;
            a.to    = bus.Timeout;
            a.tow   = bus.TimeoutOwner;
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: sample for cycle %0d taken late at cycle %0d", nm, e.cyc, cyc);
            end else if (a !== e) begin
                errors++;
                $display("FAIL %s cyc %0d: got grt=%b busy=%b owner=%0d wd=%h ad=%h wdm=%0d rdm=%0d to=%b tow=%0d, want grt=%b busy=%b owner=%0d wd=%h ad=%h wdm=%0d rdm=%0d to=%b tow=%0d",
                         nm, cyc, a.grt, a.busy, a.owner, a.wdata, a.addr, a.wdm, a.rdm, a.to, a.tow,
                         e.grt, e.busy, e.owner, e.wdata, e.addr, e.wdm, e.rdm, e.to, e.tow);
            end
        end
    end

    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        Rst     = 1'b1;
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            bus.ReqWriteBus[32*i +: 32] = wdata_tab[i];
            bus.ReqAddrBus[32*i +: 32]  = addr_tab[i];
            bus.ReqWDM[2*i +: 2]        = wdm_tab[i];
            bus.ReqRDM[2*i +: 2]        = rdm_tab[i];
        end

        // Reset state and single master
        step(1'b1, 4'b0000); exp_n("reset", 3);
        step(1'b1, 4'b0000); exp_n("reset_hold", 3);
        step(1'b0, 4'b0000); exp_n("idle_after_reset", 3);
        step(1'b0, 4'b0001); exp_g("single_grant", 0);
        step(1'b0, 4'b0001); exp_g("single_hold", 0);
        step(1'b0, 4'b0000); exp_n("single_gap", 0);
        step(1'b0, 4'b0000); exp_n("single_idle", 0);

        // Round robin from a fresh reset
        step(1'b1, 4'b0000); exp_n("rr_reset", 3);
        foreach (rr_order[j]) begin
            step(1'b0, 4'hF);                             exp_g("rr_grant", rr_order[j]);
            step(1'b0, 4'hF);                             exp_g("rr_hold1", rr_order[j]);
            step(1'b0, 4'hF);                             exp_g("rr_hold2", rr_order[j]);
            step(1'b0, 4'hF & ~(4'b0001 << rr_order[j])); exp_n("rr_gap", rr_order[j]);
            step(1'b0, 4'hF);                             exp_n("rr_idle", rr_order[j]);
        end
        step(1'b0, 4'b0000); exp_n("rr_empty", 0);

        // Contention: master 2 wins after 1 releases and re-requests
        step(1'b1, 4'b0000); exp_n("ct_reset", 3);
        step(1'b0, 4'b0010); exp_g("ct_grant1", 1);
        step(1'b0, 4'b0110); exp_g("ct_hold1", 1);
        step(1'b0, 4'b0100); exp_n("ct_gap1", 1);
        step(1'b0, 4'b0110); exp_n("ct_idle1", 1);
        step(1'b0, 4'b0110); exp_g("ct_grant2", 2);
        step(1'b0, 4'b0110); exp_g("ct_hold2", 2);
        step(1'b0, 4'b0010); exp_n("ct_gap2", 2);
        step(1'b0, 4'b0010); exp_n("ct_idle2", 2);
        step(1'b0, 4'b0010); exp_g("ct_regrant1", 1);
        step(1'b0, 4'b0000); exp_n("ct_gap3", 1);
        step(1'b0, 4'b0000); exp_n("ct_idle3", 1);

        // Watchdog: master 0 hogs while master 3 waits
        step(1'b1, 4'b0000); exp_n("wd_reset", 3);
        step(1'b0, 4'b1001); exp_g("wd_grant0", 0);
        step(1'b0, 4'b1001); exp_g("wd_hold2", 0);
        step(1'b0, 4'b1001); exp_g("wd_hold3", 0);
        step(1'b0, 4'b1001); exp_g("wd_hold4", 0);
        e_to = 1'b1; e_tow = 2'd0;
        step(1'b0, 4'b1001); exp_n("wd_force", 0);
        step(1'b0, 4'b1001); exp_n("wd_idle", 0);
        step(1'b0, 4'b1001); exp_g("wd_grant3", 3);
        step(1'b0, 4'b0001); exp_n("wd_gap3", 3);
        step(1'b0, 4'b0001); exp_n("wd_idle3", 3);
        step(1'b0, 4'b0001); exp_n("wd_masked", 3);
        step(1'b0, 4'b0000); exp_n("wd_drop", 3);
        step(1'b0, 4'b0001); exp_g("wd_regrant0", 0);
        step(1'b0, 4'b0010); exp_n("wd_gap0", 0);
        step(1'b0, 4'b0010); exp_n("wd_idle0", 0);
        step(1'b0, 4'b0010); exp_g("mg_grant1", 1);

        // Reset while master 1 owns the bus clears Timeout as well
        e_to = 1'b0; e_tow = 2'd0;
        step(1'b1, 4'b0010); exp_n("mg_reset", 3);
        step(1'b0, 4'b0000); exp_n("mg_idle", 3);

        // Lone hog is never force-released
        for (int n = 0; n < 20; n++) begin
            step(1'b0, 4'b0100); exp_g("hog", 2);
        end
        // Drop coinciding with a saturated counter is a normal release
        step(1'b0, 4'b1000); exp_n("hog_drop_gap", 2);
        step(1'b0, 4'b1000); exp_n("hog_idle", 2);
        step(1'b0, 4'b1000); exp_g("hog_next3", 3);
        step(1'b0, 4'b0000); exp_n("end_gap", 3);
        step(1'b0, 4'b0000); exp_n("end_idle", 3);

        repeat (5) begin
            if (exp_q.size() == 0) break;
            @(posedge Clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
